// File: rtl/seg7_result_display_pkg.sv
// Shared definitions for the result display: FSM states, the active-high
// 7-segment font ({g,f,e,d,c,b,a}), and the double-dabble nibble correction.
package seg7_result_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Active-high font, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index of the last shift step (8 shifts for an 8-bit input)
  localparam logic [2:0] CNT_LAST = 3'd7;

  // Double-dabble correction applied to each BCD nibble before a shift
  function automatic logic [3:0] dabble_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/seg7_result_display_if.sv
// Bundle between the ALU result mux and the display block.
//   value[7:0], dp_mul_n, dp_div_n : result byte and active-low dp flags
//   busy, done                     : conversion status / update pulse
//   hex2, hex1, hex0 [7:0]         : {dp,g,f,e,d,c,b,a} per digit
// master = producer of the result (mux side), slave = display block.
interface seg7_result_display_if;
  logic [7:0] value;
  logic       dp_mul_n;
  logic       dp_div_n;
  logic       busy;
  logic       done;
  logic [7:0] hex2;
  logic [7:0] hex1;
  logic [7:0] hex0;

  modport master (
    output value, dp_mul_n, dp_div_n,
    input  busy, done, hex2, hex1, hex0
  );

  modport slave (
    input  value, dp_mul_n, dp_div_n,
    output busy, done, hex2, hex1, hex0
  );
endinterface

// File: rtl/seg7_result_display_decode.sv
// Nibble to active-high 7-segment pattern {g,f,e,d,c,b,a}. Purely
// combinational. Codes 10..15 never occur for a byte in BCD and decode blank.
//   nibble[3:0] : BCD digit
//   seg[6:0]    : lit segments, 1 = on
module seg7_result_display_decode
  import seg7_result_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_result_display.sv
// Result byte to three 7-segment digits (HEX2..HEX0).
// A change on {value,dp_mul_n,dp_div_n} seen in IDLE is captured and converted
// to BCD by an 8-step sequential double-dabble; the three digit outputs are
// registered together in DONE, so they always reflect one coherent capture.
//   clk, rst     : single clock, synchronous active-high reset
//   bus (slave)  : value/dp flags in; busy, done, hex2/1/0 out
// Parameters:
//   SEG_ACTIVE_LOW : 1 -> lit segment drives 0; 0 -> lit segment drives 1
//   BLANK_LZ       : 1 -> suppress leading zeros on hex2/hex1
module seg7_result_display
  import seg7_result_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  seg7_result_display_if.slave bus
);

  localparam logic [7:0] HEX_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  state_t      state, state_n;
  logic        start;
  logic        force_conv;
  logic [7:0]  cap_val, last_val;
  logic        cap_dpm, cap_dpd, last_dpm, last_dpd;
  logic [11:0] bcd, bcd_adj;
  logic [2:0]  cnt;
  logic        done_q;
  logic [7:0]  hex2_q, hex1_q, hex0_q;

  logic [6:0]  seg_h, seg_t, seg_o;
  logic        blank_h, blank_t;
  logic [7:0]  raw2, raw1, raw0;

  function automatic logic [7:0] polarity(input logic [7:0] raw);
    return SEG_ACTIVE_LOW ? ~raw : raw;
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (force_conv ||
            ({bus.value, bus.dp_mul_n, bus.dp_div_n} != {last_val, last_dpm, last_dpd})) begin
          start   = 1'b1;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: if (cnt == CNT_LAST) state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // ---------------- double-dabble step ----------------
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 3; i++) begin
      bcd_adj[4*i +: 4] = dabble_adj(bcd[4*i +: 4]);
    end
  end

  // ---------------- digit formatting ----------------
  seg7_result_display_decode u_dec_h (.nibble(bcd[11:8]), .seg(seg_h));
  seg7_result_display_decode u_dec_t (.nibble(bcd[7:4]),  .seg(seg_t));
  seg7_result_display_decode u_dec_o (.nibble(bcd[3:0]),  .seg(seg_o));

  always_comb begin
    blank_h = BLANK_LZ && (bcd[11:8] == 4'd0);
    blank_t = blank_h && (bcd[7:4] == 4'd0);
    // dp flags arrive active-low; raw patterns are active-high
    raw2 = {~cap_dpm, blank_h ? SEG_BLANK : seg_h};
    raw1 = {1'b0,     blank_t ? SEG_BLANK : seg_t};
    raw0 = {~cap_dpd, seg_o};
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      force_conv <= 1'b1;
      done_q     <= 1'b0;
      hex2_q     <= HEX_OFF;
      hex1_q     <= HEX_OFF;
      hex0_q     <= HEX_OFF;
      cnt        <= '0;
      bcd        <= '0;
      cap_val    <= '0;
      cap_dpm    <= 1'b1;
      cap_dpd    <= 1'b1;
      last_val   <= '0;
      last_dpm   <= 1'b1;
      last_dpd   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cap_val    <= bus.value;
            cap_dpm    <= bus.dp_mul_n;
            cap_dpd    <= bus.dp_div_n;
            last_val   <= bus.value;
            last_dpm   <= bus.dp_mul_n;
            last_dpd   <= bus.dp_div_n;
            bcd        <= '0;
            cnt        <= '0;
            force_conv <= 1'b0;
          end
        end
        ST_SHIFT: begin
          // cap_val is consumed MSB-first; last_val keeps the compare copy
          {bcd, cap_val} <= {bcd_adj, cap_val} << 1;
          cnt            <= cnt + 3'd1;
        end
        ST_DONE: begin
          hex2_q <= polarity(raw2);
          hex1_q <= polarity(raw1);
          hex0_q <= polarity(raw0);
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = done_q;
  assign bus.hex2 = hex2_q;
  assign bus.hex1 = hex1_q;
  assign bus.hex0 = hex0_q;

endmodule
